// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: memory, PC and ALU control bundle between the sequencer and its datapath.
interface cpu_sequencer_if #(parameter int WORD_SIZE = 19);
  logic                 start;
  logic [WORD_SIZE-1:0] execadd;
  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_valid;
  logic                 load_pc;
  logic                 inc_pc;
  logic [WORD_SIZE-1:0] pc_address;
  logic                 zero_flag;
  logic [WORD_SIZE-1:0] ir;
  logic                 alu_en;
  logic                 reg_we;
  logic                 illegal;
  logic                 halted;
  modport master (
    input  start, execadd, mem_rdata, mem_valid, zero_flag,
    output mem_req, mem_addr, load_pc, inc_pc, pc_address, ir, alu_en, reg_we, illegal, halted
  );
  modport slave (
    output start, execadd, mem_rdata, mem_valid, zero_flag,
    input  mem_req, mem_addr, load_pc, inc_pc, pc_address, ir, alu_en, reg_we, illegal, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute control FSM driving PC commands, memory requests and ALU strobes.
module cpu_sequencer #(
  parameter int WORD_SIZE = 19,
  parameter int OPCODE_W  = 5
) (
  input logic             i_clk,
  input logic             i_rst_n,
  cpu_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETTLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(5'h10);
  localparam logic [OPCODE_W-1:0] OP_JZ   = OPCODE_W'(5'h11);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(5'h1F);
  state_t               r_state, w_next;
  logic [WORD_SIZE-1:0] r_ir;
  logic [OPCODE_W-1:0]  w_op;
  logic                 w_alu, w_jmp, w_hlt, w_ill, w_take;
  logic                 w_ld, w_inc, w_alu_en, w_ill_p;
  assign w_op   = r_ir[WORD_SIZE-1 -: OPCODE_W];
  assign w_alu  = (w_op != '0) && (w_op < OP_JMP);
  assign w_jmp  = w_op == OP_JMP;
  assign w_hlt  = w_op == OP_HALT;
  assign w_ill  = (w_op > OP_JZ) && !w_hlt;
  assign w_take = w_jmp || (w_op == OP_JZ && bus.zero_flag);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.mem_valid) r_ir <= bus.mem_rdata;
    end
  end
  always_comb begin
    w_next   = r_state;
    w_ld     = 1'b1;
    w_inc    = 1'b1;
    w_alu_en = 1'b0;
    w_ill_p  = 1'b0;
    case (r_state)
      S_IDLE:   w_next = bus.start ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        w_ld   = 1'b0;
        w_inc  = 1'b0;
        w_next = S_SETTLE;
      end
      S_SETTLE: w_next = S_FETCH;
      S_FETCH:  w_next = bus.mem_valid ? S_DECODE : S_FETCH;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_alu_en = w_alu;
        w_ill_p  = w_ill;
        w_ld     = w_take || w_hlt;
        w_inc    = !w_take;
        w_next   = w_hlt ? S_HALT : S_WB;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = bus.start ? S_CLEAR : S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end
  // PC command is forced to "clear" while reset is held so the PC zeroes with the sequencer
  assign bus.load_pc    = i_rst_n && w_ld;
  assign bus.inc_pc     = i_rst_n && w_inc;
  assign bus.mem_req    = r_state == S_FETCH;
  assign bus.mem_addr   = bus.execadd;
  assign bus.pc_address = {{OPCODE_W{1'b0}}, r_ir[WORD_SIZE-OPCODE_W-1:0]};
  assign bus.ir         = r_ir;
  assign bus.alu_en     = w_alu_en;
  assign bus.illegal    = w_ill_p;
  assign bus.reg_we     = r_state == S_WB && w_alu;
  assign bus.halted     = r_state == S_HALT;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed program run against a PC/memory model with an expected-instruction scoreboard.
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] pc, execadd;
  logic [18:0] mem [0:31];
  int          cnt, wait_cycles;
  int          checks = 0, passes = 0;
  typedef struct {
    logic [18:0] addr;
    logic [18:0] word;
    logic [18:0] target;
    int          waits;
    logic        zf, alu, ill, ld, inc, halt;
  } rec_t;
  rec_t sb[$];
  cpu_sequencer_if bus ();
  cpu_sequencer dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      execadd <= '0;
    end else begin
      case ({bus.load_pc, bus.inc_pc})
        2'b00:   pc <= '0;
        2'b10:   pc <= bus.pc_address;
        2'b01:   pc <= pc + 19'd1;
        default: pc <= pc;
      endcase
      execadd <= pc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else cnt <= (bus.mem_req && !bus.mem_valid) ? cnt + 1 : 0;
  end
  assign bus.execadd   = execadd;
  assign bus.mem_valid = bus.mem_req && cnt == wait_cycles;
  assign bus.mem_rdata = mem[bus.mem_addr[4:0]];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic push(input logic [18:0] addr, input logic [4:0] op, input logic [13:0] tgt, input int waits,
                      input logic zf, alu, ill, ld, inc, halt);
    rec_t r;
    r.addr = addr; r.word = {op, tgt}; r.target = {5'd0, tgt}; r.waits = waits;
    r.zf = zf; r.alu = alu; r.ill = ill; r.ld = ld; r.inc = inc; r.halt = halt;
    mem[addr[4:0]] = r.word;
    sb.push_back(r);
  endtask
  task automatic run_one;
    rec_t e;
    int   n;
    e = sb.pop_front();
    wait_cycles = e.waits;
    bus.zero_flag = e.zf;
    n = 0;
    while (!bus.mem_req && n < 20) begin step; n++; end
    chk("req_seen", bus.mem_req, 1);
    chk("fetch_addr", bus.mem_addr, e.addr);
    n = 0;
    while (bus.mem_req && n < 20) begin step; n++; end
    chk("req_cycles", n, e.waits + 1);
    chk("decode_ir", bus.ir, e.word);
    chk("decode_strobes", {bus.alu_en, bus.illegal, bus.reg_we}, 0);
    step;
    chk("exec_alu_en", bus.alu_en, e.alu);
    chk("exec_illegal", bus.illegal, e.ill);
    chk("exec_pc_cmd", {bus.load_pc, bus.inc_pc}, {e.ld, e.inc});
    chk("exec_halted", bus.halted, 0);
    if (e.ld && !e.inc) chk("exec_target", bus.pc_address, e.target);
    if (e.halt) begin
      bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      chk("halt_state", bus.halted, 1);
    end else begin
      step;
      chk("wb_reg_we", bus.reg_we, e.alu);
      chk("wb_pulses_gone", {bus.alu_en, bus.illegal}, 0);
      chk("wb_pc_hold", {bus.load_pc, bus.inc_pc}, 2'b11);
      step;
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.zero_flag = 1'b0;
    wait_cycles = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    step;
    step;
    chk("rst_pc_cmd", {bus.load_pc, bus.inc_pc}, 2'b00);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_ir", bus.ir, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_strobes", {bus.alu_en, bus.reg_we, bus.illegal}, 0);
    rst_n = 1'b1;
    step;
    chk("idle_pc_cmd", {bus.load_pc, bus.inc_pc}, 2'b11);
    chk("idle_mem_req", bus.mem_req, 0);
    push(19'h00000, 5'h00, 14'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(19'h00001, 5'h05, 14'h0ABC, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(19'h00002, 5'h10, 14'h1234, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(19'h01234, 5'h11, 14'h0103, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(19'h00103, 5'h11, 14'h0107, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(19'h00104, 5'h15, 14'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(19'h00105, 5'h1F, 14'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    chk("clear_pc_cmd", {bus.load_pc, bus.inc_pc}, 2'b00);
    chk("clear_mem_req", bus.mem_req, 0);
    step;
    chk("settle_pc_cmd", {bus.load_pc, bus.inc_pc}, 2'b11);
    chk("settle_mem_req", bus.mem_req, 0);
    step;
    chk("first_req_at_2", bus.mem_req, 1);
    while (sb.size() > 0) run_one();
    chk("halt_pc_cmd", {bus.load_pc, bus.inc_pc}, 2'b11);
    step;
    step;
    chk("halt_held", bus.halted, 1);
    chk("halt_pc_kept", execadd, 19'h00105);
    bus.start = 1'b1;
    wait_cycles = 10;
    step;
    bus.start = 1'b0;
    chk("restart_clear", {bus.load_pc, bus.inc_pc}, 2'b00);
    chk("restart_halted_low", bus.halted, 0);
    step;
    step;
    chk("restart_req", bus.mem_req, 1);
    chk("restart_addr", bus.mem_addr, 0);
    step;
    step;
    chk("pre_rst_ir", bus.ir, {5'h1F, 14'h0000});
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", bus.mem_req, 0);
    chk("async_rst_pc_cmd", {bus.load_pc, bus.inc_pc}, 2'b00);
    chk("async_rst_ir", bus.ir, 0);
    step;
    rst_n = 1'b1;
    step;
    chk("post_rst_idle_cmd", {bus.load_pc, bus.inc_pc}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("post_rst_no_req", bus.mem_req, 0);
    end
    chk("post_rst_ir", bus.ir, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
